// File: rtl/resp_alarma_pkg.sv
// Shared types and helpers for the alarm responder: state encoding and timer sizing.
package resp_alarma_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    EXIT  = 3'd1,
    ARMED = 3'd2,
    ENTRY = 3'd3,
    ALARM = 3'd4
  } state_t;

  // Width able to hold the largest reload value (longest delay minus one).
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/resp_alarma_cnt_desc.sv
// Loadable down-counter that saturates at zero; shared by the exit, entry and siren delays.
module cnt_desc #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         zero
);

  assign zero = (value == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && !zero) begin
      value <= value - W'(1);
    end
  end

endmodule

// File: rtl/resp_alarma.sv
// Alarm responder: keypad arming/disarming, exit/entry delays, timed siren,
// alarm memory and wrong-code lockout driven from the zone sensor bank.
module resp_alarma
  import resp_alarma_pkg::*;
#(
  parameter int         EXIT_CYC  = 16,
  parameter int         ENTRY_CYC = 8,
  parameter int         SIREN_CYC = 32,
  parameter logic [3:0] CODE      = 4'hA,
  parameter int         MAX_FAIL  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   S,
  input  logic         M,
  input  logic         arm,
  input  logic         code_valid,
  input  logic [3:0]   code,
  output logic [2:0]   state,
  output logic         armed,
  output logic         siren,
  output logic         light,
  output logic         beep,
  output logic         alarm_mem,
  output logic         fault
);

  localparam int TW = timer_width(EXIT_CYC, ENTRY_CYC, SIREN_CYC);
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_CYC - 1);
  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_CYC - 1);
  localparam logic [TW-1:0] SIREN_LOAD = TW'(SIREN_CYC - 1);
  localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAIL - 1);

  state_t        state_reg, state_next;
  logic [FW-1:0] fail_reg, fail_next;
  logic          mem_reg, mem_next;
  logic          fault_reg, fault_next;
  logic          beep_reg, beep_next;
  logic          armed_reg, siren_reg, light_reg;

  logic          breach, good, bad;
  logic          timer_load, timer_en, timer_zero;
  logic [TW-1:0] timer_load_val, timer_val;

  assign breach = ~(&S) & ~M;
  assign good   = code_valid & (code == CODE);
  assign bad    = code_valid & (code != CODE);

  // Every state change reloads the timer, so it never carries over between delays.
  assign timer_load = (state_next != state_reg);
  assign timer_en   = (state_reg == EXIT) || (state_reg == ENTRY) || (state_reg == ALARM);

  always_comb begin
    timer_load_val = '0;
    case (state_next)
      EXIT:    timer_load_val = EXIT_LOAD;
      ENTRY:   timer_load_val = ENTRY_LOAD;
      ALARM:   timer_load_val = SIREN_LOAD;
      default: timer_load_val = '0;
    endcase
  end

  cnt_desc #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .en       (timer_en),
    .value    (timer_val),
    .zero     (timer_zero)
  );

  always_comb begin
    state_next = state_reg;
    fail_next  = fail_reg;
    mem_next   = mem_reg;
    fault_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (good) begin
          mem_next = 1'b0;
        end else if (arm) begin
          if (breach) fault_next = 1'b1;
          else        state_next = EXIT;
        end
      end
      EXIT, ARMED, ENTRY: begin
        if (good) begin
          state_next = IDLE;
          fail_next  = '0;
        end else if (bad && (fail_reg == FAIL_LAST)) begin
          state_next = ALARM;
          fail_next  = '0;
        end else begin
          if (bad) fail_next = fail_reg + FW'(1);
          if ((state_reg == EXIT) && timer_zero)       state_next = ARMED;
          else if ((state_reg == ARMED) && breach)     state_next = ENTRY;
          else if ((state_reg == ENTRY) && timer_zero) state_next = ALARM;
        end
      end
      ALARM: begin
        // Maintenance mode and wrong codes cannot cut a running siren short.
        if (good) begin
          state_next = IDLE;
          fail_next  = '0;
        end else if (timer_zero) begin
          state_next = ARMED;
        end
      end
      default: state_next = IDLE;
    endcase
    if ((state_next == ALARM) && (state_reg != ALARM)) mem_next = 1'b1;
  end

  // Beep starts low on entry to a delay state and toggles while it stays there.
  always_comb begin
    beep_next = 1'b0;
    if (((state_next == EXIT) || (state_next == ENTRY)) && (state_next == state_reg))
      beep_next = ~beep_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      fail_reg  <= '0;
      mem_reg   <= 1'b0;
      fault_reg <= 1'b0;
      beep_reg  <= 1'b0;
      armed_reg <= 1'b0;
      siren_reg <= 1'b0;
      light_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      fail_reg  <= fail_next;
      mem_reg   <= mem_next;
      fault_reg <= fault_next;
      beep_reg  <= beep_next;
      armed_reg <= (state_next == ARMED) || (state_next == ENTRY) || (state_next == ALARM);
      siren_reg <= (state_next == ALARM);
      light_reg <= (state_next == ENTRY) || (state_next == ALARM);
    end
  end

  assign state     = state_reg;
  assign armed     = armed_reg;
  assign siren     = siren_reg;
  assign light     = light_reg;
  assign beep      = beep_reg;
  assign alarm_mem = mem_reg;
  assign fault     = fault_reg;

  a_timer_rest: assert property (@(posedge clk) disable iff (!rst_n)
    ((state_reg == IDLE) || (state_reg == ARMED)) |-> (timer_val == '0));

endmodule

// File: tb/tb_resp_alarma.sv
// Scenario bench for resp_alarma: expected outputs are queued per driven cycle and checked after the edge.
module tb_resp_alarma;

  localparam logic [2:0] S_IDLE = 3'd0, S_EXIT = 3'd1, S_ARMED = 3'd2, S_ENTRY = 3'd3, S_ALARM = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] s = 6'h3F;
  logic       m = 1'b0;
  logic       arm = 1'b0;
  logic       code_valid = 1'b0;
  logic [3:0] code = 4'h0;
  logic [2:0] state;
  logic       armed, siren, light, beep, alarm_mem, fault;

  int checks = 0;
  int failures = 0;
  logic [8:0] expq[$];

  resp_alarma #(
    .EXIT_CYC(4), .ENTRY_CYC(3), .SIREN_CYC(5), .CODE(4'h5), .MAX_FAIL(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .S(s), .M(m), .arm(arm), .code_valid(code_valid), .code(code),
    .state(state), .armed(armed), .siren(siren), .light(light), .beep(beep),
    .alarm_mem(alarm_mem), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] pack(input logic [2:0] st, input logic bp, input logic mem, input logic flt);
    logic a, sr, l;
    a  = (st == S_ARMED) || (st == S_ENTRY) || (st == S_ALARM);
    sr = (st == S_ALARM);
    l  = (st == S_ENTRY) || (st == S_ALARM);
    return {st, a, sr, l, bp, mem, flt};
  endfunction

  // One clock: queue what must appear after this edge, clock it, compare, drop pulses.
  task automatic step(input string nm, input logic [2:0] st, input logic bp, input logic mem, input logic flt);
    logic [8:0] exp_v, got_v;
    expq.push_back(pack(st, bp, mem, flt));
    @(posedge clk);
    #1;
    arm = 1'b0;
    code_valid = 1'b0;
    got_v = {state, armed, siren, light, beep, alarm_mem, fault};
    exp_v = expq.pop_front();
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got {state,armed,siren,light,beep,mem,fault}=%b required %b", nm, got_v, exp_v);
    end else begin
      $display("ok   %s: state=%0d outputs=%b", nm, state, got_v[5:0]);
    end
  endtask

  task automatic arm_clean();
    s = 6'h3F; m = 1'b0; arm = 1'b1;
    step("arm_exit0", S_EXIT, 1'b0, alarm_mem, 1'b0);
    step("arm_exit1", S_EXIT, 1'b1, alarm_mem, 1'b0);
    step("arm_exit2", S_EXIT, 1'b0, alarm_mem, 1'b0);
    step("arm_exit3", S_EXIT, 1'b1, alarm_mem, 1'b0);
    step("arm_armed", S_ARMED, 1'b0, alarm_mem, 1'b0);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({state, armed, siren, light, beep, alarm_mem, fault} !== 9'b0) begin
      failures++;
      $display("FAIL reset_state: got %b required 000000000",
               {state, armed, siren, light, beep, alarm_mem, fault});
    end else $display("ok   reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_idle", S_IDLE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_entry_expiry();
    s = 6'b011111;
    step("entry0", S_ENTRY, 1'b0, 1'b0, 1'b0);
    step("entry1", S_ENTRY, 1'b1, 1'b0, 1'b0);
    step("entry2", S_ENTRY, 1'b0, 1'b0, 1'b0);
    step("alarm0", S_ALARM, 1'b0, 1'b1, 1'b0);
    s = 6'h3F;
    for (int i = 1; i < 5; i++) step($sformatf("alarm%0d", i), S_ALARM, 1'b0, 1'b1, 1'b0);
    step("rearm", S_ARMED, 1'b0, 1'b1, 1'b0);
    s = 6'b011111;
    step("reentry", S_ENTRY, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_disarm();
    code_valid = 1'b1; code = 4'h5;
    step("disarm_entry", S_IDLE, 1'b0, 1'b1, 1'b0);
    s = 6'h3F;
    code_valid = 1'b1; code = 4'h5;
    step("clear_mem", S_IDLE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_rejected_arm();
    s = 6'b111110; m = 1'b0; arm = 1'b1;
    step("arm_reject", S_IDLE, 1'b0, 1'b0, 1'b1);
    step("fault_end", S_IDLE, 1'b0, 1'b0, 1'b0);
    m = 1'b1; arm = 1'b1;
    step("maint_exit0", S_EXIT, 1'b0, 1'b0, 1'b0);
    step("maint_exit1", S_EXIT, 1'b1, 1'b0, 1'b0);
    step("maint_exit2", S_EXIT, 1'b0, 1'b0, 1'b0);
    step("maint_exit3", S_EXIT, 1'b1, 1'b0, 1'b0);
    step("maint_armed", S_ARMED, 1'b0, 1'b0, 1'b0);
    step("maint_masked0", S_ARMED, 1'b0, 1'b0, 1'b0);
    step("maint_masked1", S_ARMED, 1'b0, 1'b0, 1'b0);
    code_valid = 1'b1; code = 4'h5;
    step("maint_disarm", S_IDLE, 1'b0, 1'b0, 1'b0);
    m = 1'b0; s = 6'h3F;
  endtask

  task automatic test_lockout();
    arm_clean();
    code_valid = 1'b1; code = 4'h3;
    step("bad_first", S_ARMED, 1'b0, 1'b0, 1'b0);
    code_valid = 1'b1; code = 4'h3;
    step("bad_lockout", S_ALARM, 1'b0, 1'b1, 1'b0);
    code_valid = 1'b1; code = 4'h5;
    step("lock_disarm", S_IDLE, 1'b0, 1'b1, 1'b0);
    code_valid = 1'b1; code = 4'h5;
    step("lock_clear", S_IDLE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    arm_clean();
    s = 6'b011111;
    step("prio_entry0", S_ENTRY, 1'b0, 1'b0, 1'b0);
    step("prio_entry1", S_ENTRY, 1'b1, 1'b0, 1'b0);
    step("prio_entry2", S_ENTRY, 1'b0, 1'b0, 1'b0);
    code_valid = 1'b1; code = 4'h5;
    step("good_over_expiry", S_IDLE, 1'b0, 1'b0, 1'b0);
    s = 6'h3F;
  endtask

  task automatic test_reset_mid_alarm();
    arm_clean();
    code_valid = 1'b1; code = 4'h9;
    step("mid_bad1", S_ARMED, 1'b0, 1'b0, 1'b0);
    code_valid = 1'b1; code = 4'h9;
    step("mid_bad2", S_ALARM, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, siren, alarm_mem, armed, light} !== 7'b0) begin
      failures++;
      $display("FAIL async_reset_alarm: got state=%0d siren=%b mem=%b armed=%b light=%b required all 0",
               state, siren, alarm_mem, armed, light);
    end else $display("ok   async_reset_alarm");
    @(negedge clk);
    rst_n = 1'b1;
    step("after_reset", S_IDLE, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    arm_clean();
    test_entry_expiry();
    test_disarm();
    test_rejected_arm();
    test_lockout();
    test_priority();
    test_reset_mid_alarm();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
